// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the ccff chain loader.
// Optional parity word is enabled with `define CCFF_LOADER_PARITY_EN.
package ccff_loader_pkg;

  localparam int CCFF_CHAIN_LEN_DEFAULT = 17;  // frac_lut4: 16 LUT SRAM bits + 1 mode bit

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } ccff_ld_state_t;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out register feeding ccff_head; head is registered.
// With CCFF_LOADER_PARITY_EN it also accumulates the XOR of every presented bit.
module ccff_piso
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load_en,
  input  logic              shift_en,
`ifdef CCFF_LOADER_PARITY_EN
  input  logic              par_clr,
  output logic              parity,
`endif
  input  logic [WORD_W-1:0] word_data,
  output logic              head
);

  logic [WORD_W-1:0] sr_r;
  logic              head_r;

  // Present bit 0 on load, then walk the remaining bits down one per shift
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sr_r   <= '0;
      head_r <= 1'b0;
    end else if (load_en) begin
      head_r <= word_data[0];
      sr_r   <= word_data >> 1'b1;
    end else if (shift_en) begin
      head_r <= sr_r[0];
      sr_r   <= sr_r >> 1'b1;
    end else begin
      sr_r   <= sr_r;
      head_r <= head_r;
    end
  end

  assign head = head_r;

`ifdef CCFF_LOADER_PARITY_EN
  logic parity_r;

  // Running parity over exactly the bits that reach ccff_head
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      parity_r <= 1'b0;
    end else if (par_clr) begin
      parity_r <= 1'b0;
    end else if (load_en) begin
      parity_r <= parity_step(parity_r, word_data[0]);
    end else if (shift_en) begin
      parity_r <= parity_step(parity_r, sr_r[0]);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity = parity_r;
`endif

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a CHAIN_LEN-bit ccff chain from WORD_W-bit words, LSB first.
// Define CCFF_LOADER_PARITY_EN to expect a trailing parity word and drive error.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEFAULT,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int WB_W  = cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [WB_W-1:0]  WORD_LAST  = WB_W'(WORD_W);
  localparam logic [WB_W-1:0]  WB_ONE     = WB_W'(1'b1);

  ccff_ld_state_t   state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;    // bits presented on ccff_head this load
  logic [WB_W-1:0]  wbits_r, wbits_s; // bits presented from the current word
  logic             load_en_s, step_en_s;
  logic             word_ready_r, busy_r, done_r, shift_en_r;

`ifdef CCFF_LOADER_PARITY_EN
  logic clr_s, parity_s, err_s, error_r;
`endif

  ccff_piso #(.WORD_W(WORD_W)) u_piso (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load_en    (load_en_s),
    .shift_en   (step_en_s),
`ifdef CCFF_LOADER_PARITY_EN
    .par_clr    (clr_s),
    .parity     (parity_s),
`endif
    .word_data  (word_data),
    .head       (ccff_head)
  );

  // Next-state and datapath control; abort overrides every transition
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    wbits_s   = wbits_r;
    load_en_s = 1'b0;
    step_en_s = 1'b0;
`ifdef CCFF_LOADER_PARITY_EN
    clr_s     = 1'b0;
    err_s     = error_r;
`endif
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_LOAD;
            cnt_s   = '0;
            wbits_s = '0;
`ifdef CCFF_LOADER_PARITY_EN
            clr_s   = 1'b1;
            err_s   = 1'b0;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            state_s   = ST_SHIFT;
            load_en_s = 1'b1;
            cnt_s     = cnt_r + CNT_ONE;
            wbits_s   = WB_ONE;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          // Chain length is checked first so unused high bits of the last word are dropped
          if (cnt_r == CHAIN_LAST) begin
`ifdef CCFF_LOADER_PARITY_EN
            state_s = ST_CHECK;
`else
            state_s = ST_DONE;
`endif
          end else if (wbits_r == WORD_LAST) begin
            state_s = ST_LOAD;
          end else begin
            state_s   = ST_SHIFT;
            step_en_s = 1'b1;
            cnt_s     = cnt_r + CNT_ONE;
            wbits_s   = wbits_r + WB_ONE;
          end
        end
        ST_CHECK: begin
`ifdef CCFF_LOADER_PARITY_EN
          if (word_valid) begin
            state_s = ST_DONE;
            err_s   = error_r | (word_data[0] ^ parity_s);
          end else begin
            state_s = ST_CHECK;
          end
`else
          state_s = ST_IDLE;
`endif
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered status outputs decoded from the next state
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      wbits_r      <= '0;
      word_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      shift_en_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      wbits_r      <= wbits_s;
      word_ready_r <= (state_s == ST_LOAD) || (state_s == ST_CHECK);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      shift_en_r   <= (state_s == ST_SHIFT);
    end
  end

`ifdef CCFF_LOADER_PARITY_EN
  // Sticky parity error, cleared by an accepted start
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= err_s;
    end
  end

  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign word_ready    = word_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign ccff_shift_en = shift_en_r;

endmodule
